// File: rtl/decode_buffer_if.sv
// Fetch-side and issue-side signal bundle for decode_buffer.
// master = fetch/issue environment, slave = the buffer itself.
interface decode_buffer_if #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);
  localparam int DW = $clog2(ISSUE_W + 1);

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [FETCH_W-1:0][31:0]  in_instr;
  logic [FETCH_W-1:0]        in_mask;
  logic [63:0]               in_pc;
  logic [ISSUE_W-1:0]        out_valid;
  logic [ISSUE_W-1:0][31:0]  out_instr;
  logic [ISSUE_W-1:0][63:0]  out_pc;
  logic [ISSUE_W-1:0][2:0]   out_class;
  logic [ISSUE_W-1:0]        out_illegal;
  logic [DW-1:0]             out_deq;

  modport master (
    output flush, in_valid, in_instr, in_mask, in_pc, out_deq,
    input  in_ready, out_valid, out_instr, out_pc, out_class, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_mask, in_pc, out_deq,
    output in_ready, out_valid, out_instr, out_pc, out_class, out_illegal
  );
endinterface

// File: rtl/decode_buffer.sv
// Circular instruction queue between fetch and issue; predecodes class and
// RV64IM+Zicsr legality at enqueue and presents the oldest ISSUE_W entries.
module decode_buffer #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  decode_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  cls;
    logic        ill;
  } entry_t;

  entry_t         r_mem [DEPTH];
  logic [PW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count;

  logic [CW-1:0]  w_free, w_cnt, w_nenq, w_ndeq, w_deq_req;
  logic           w_ready, w_push;
  logic [PW-1:0]  w_slot [FETCH_W];
  entry_t         w_new  [FETCH_W];
  logic [PW-1:0]  w_ridx [ISSUE_W];

  function automatic logic [2:0] f_class(input logic [31:0] i);
    logic [2:0] c;
    c = 3'd0;
    if ((i[6:0] == OP_OP || i[6:0] == OP_OP32) && i[31:25] == 7'b0000001) c = 3'd5;
    else begin
      case (i[6:0])
        OP_BRANCH:        c = 3'd1;
        OP_JAL, OP_JALR:  c = 3'd2;
        OP_LOAD:          c = 3'd3;
        OP_STORE:         c = 3'd4;
        OP_SYSTEM:        c = 3'd6;
        OP_MISC:          c = 3'd7;
        default:          c = 3'd0;
      endcase
    end
    return c;
  endfunction

  function automatic logic f_illegal(input logic [31:0] i);
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    bad = 1'b0;
    f3  = i[14:12];
    f7  = i[31:25];
    f6  = i[31:26];
    case (i[6:0])
      OP_OP, OP_OP32: begin
        if (!(f7 inside {7'h00, 7'h20, 7'h01})) bad = 1'b1;
        if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) bad = 1'b1;
        if (i[6:0] == OP_OP32 && (f3 inside {3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) && f7 != 7'h01) bad = 1'b1;
      end
      OP_IMM: begin
        if (f3 == 3'd1 && f6 != 6'h00) bad = 1'b1;
        if (f3 == 3'd5 && !(f6 inside {6'h00, 6'h10})) bad = 1'b1;
      end
      OP_IMM32: begin
        if (!(f3 inside {3'd0, 3'd1, 3'd5})) bad = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) bad = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL, OP_MISC: bad = 1'b0;
      OP_JALR:   bad = (f3 != 3'd0);
      OP_BRANCH: bad = (f3 inside {3'd2, 3'd3});
      OP_LOAD:   bad = (f3 == 3'd7);
      OP_STORE:  bad = (f3 > 3'd3);
      OP_SYSTEM: begin
        if (f3 == 3'd4) bad = 1'b1;
        if (f3 == 3'd0 && !(i inside {32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073}))
          bad = 1'b1;
      end
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  always_comb begin
    w_free    = CW'(DEPTH) - r_count;
    w_ready   = !reset && (w_free >= CW'(FETCH_W));
    w_push    = bus.in_valid && w_ready && !bus.flush;
    w_deq_req = CW'(bus.out_deq);
    w_ndeq    = (w_deq_req > r_count) ? r_count : w_deq_req;
  end

  // Compaction: each set lane lands at tail + (number of set lanes below it).
  always_comb begin
    w_cnt = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      w_slot[k]       = r_tail + w_cnt[PW-1:0];
      w_new[k].instr  = bus.in_instr[k];
      w_new[k].pc     = bus.in_pc + (64'(k) << 2);
      w_new[k].cls    = f_class(bus.in_instr[k]);
      w_new[k].ill    = f_illegal(bus.in_instr[k]);
      if (bus.in_mask[k]) w_cnt = w_cnt + CW'(1);
    end
    w_nenq = w_push ? w_cnt : '0;
  end

  assign bus.in_ready = w_ready;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + w_nenq[PW-1:0];
      r_head  <= r_head + w_ndeq[PW-1:0];
      r_count <= r_count + w_nenq - w_ndeq;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int unsigned k = 0; k < FETCH_W; k++)
        if (bus.in_mask[k]) r_mem[w_slot[k]] <= w_new[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (w_deq_req <= r_count);
  end

  always_comb begin
    bus.out_valid   = '0;
    bus.out_instr   = '0;
    bus.out_pc      = '0;
    bus.out_class   = '0;
    bus.out_illegal = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      w_ridx[i] = r_head + PW'(i);
      if (!reset && (r_count > CW'(i))) begin
        bus.out_valid[i]   = 1'b1;
        bus.out_instr[i]   = r_mem[w_ridx[i]].instr;
        bus.out_pc[i]      = r_mem[w_ridx[i]].pc;
        bus.out_class[i]   = r_mem[w_ridx[i]].cls;
        bus.out_illegal[i] = r_mem[w_ridx[i]].ill;
      end
    end
  end
endmodule
